systolic_push_unit: RTL and testbench
=====================================

Name: systolic_push_unit

Overview:
Sits directly downstream of the warp selector. During a matmul it takes the warp named by push_warp each cycle and reads that warp's operand row from the register file. It then diagonally skews the row into the west edge of the systolic array. When all rows have been pushed and the array has drained, it pulses matmul_done back to the warp selector.

Parameters:
DIM, 4, systolic array dimension; rows pushed per matmul and lanes per row
DATA_W, 8, operand element width in bits
WARP_W, 2, warp index width (4 warps)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset
push_en  in  1  start pulse from control
push_warp  in  WARP_W  warp whose row is pushed this cycle (from warp selector)
pause  in  1  warp selector: selected warp not ready, stall
rf_rd_en  out  1  register-file read strobe
rf_rd_warp  out  WARP_W  register-file read warp index (= push_warp)
rf_rd_data  in  DIM*DATA_W  row data; combinational read, valid in the same cycle as rf_rd_en; lane i at bits [i*DATA_W +: DATA_W]
array_west_data  out  DIM*DATA_W  skewed west-edge operands, lane i drives array row i
array_en  out  1  array advance enable; array shifts only when high
busy  out  1  high in any state other than IDLE
matmul_done  out  1  one-cycle pulse at completion

Behaviour:
- Reset (reset==0 at a clk edge):
  - State IDLE; counters = 0.
  - All skew registers = 0.
  - All outputs 0.
  - Mid-operation reset aborts the matmul with no matmul_done.
- FSM states: IDLE, PUSH, DRAIN, DONE.
- IDLE:
  - push_en=1 -> PUSH next cycle; row_cnt=0.
  - push_en is ignored in every other state, including DONE.
- PUSH:
  - rf_rd_en = ~pause; rf_rd_warp = push_warp.
  - pause=0 (accepted cycle): the lane vector rf_rd_data enters skew stage 0; row_cnt++; array_en=1.
  - pause=1: no read, skew registers hold, array_en=0, row_cnt unchanged. There is no limit on stall length.
  - Leave for DRAIN after the accepted cycle where row_cnt reaches DIM-1 (the DIM-th row).
- Skew network:
  - Lane i passes through i+1 registers, so lane 0 appears on array_west_data 1 cycle after acceptance and lane DIM-1 appears DIM cycles after.
  - All skew registers shift only when array_en=1.
  - Register slots with no valid data carry 0.
- DRAIN:
  - Zeros are injected at stage 0; array_en=1; pause is ignored.
  - drain_cnt counts 2*DIM-2 cycles, then the FSM goes to DONE.
- DONE:
  - matmul_done=1 for exactly one cycle; array_en=0; next state IDLE.
  - A new push_en is accepted no earlier than the cycle after DONE.
- Latency: with no pauses, push_en at cycle 0 -> PUSH cycles 1..DIM -> DRAIN DIM+1..3*DIM-2 -> matmul_done at cycle 3*DIM-1 (11 for DIM=4). Each pause cycle adds 1.
- Widths:
  - row_cnt and drain_cnt are each sized for 2*DIM-2 (clog2).
  - push_warp is passed through to rf_rd_warp unmodified; no arithmetic is done on it.
- busy = (state != IDLE).

Decomposition:
- Shared package:
  - FSM state encoding (IDLE/PUSH/DRAIN/DONE).
  - WARP_W and a NUM_WARPS constant.
  - DIM and DATA_W defaults, shared with the warp selector and systolic array.
  - drain-length localparam 2*DIM-2.
- One sub-module: skew_delay_line (parameter DEPTH, DATA_W, with an enable). It is instantiated DIM times with DEPTH=i+1.

Test Plan:
- Reset: hold reset=0 for 2 cycles mid-PUSH -> all outputs 0, busy=0, no matmul_done, skew contents cleared (array_west_data=0 on the first cycles after release).
- Clean matmul (DIM=4): push_en at cycle 0, pause=0, push_warp 0,1,2,3 with rows 0x04030201, 0x08070605, 0x0C0B0A09, 0x100F0E0D.
  - rf_rd_warp = 0,1,2,3 in cycles 1-4.
  - Lane 0 shows 01,05,09,0D in cycles 2-5; lane 3 shows 04,08,0C,10 in cycles 5-8.
  - matmul_done pulses only in cycle 11.
- Pause: assert pause for 3 cycles after the second row -> rf_rd_en=0 and array_en=0 during those cycles, array_west_data frozen, matmul_done in cycle 14.
- Pause during DRAIN: pause=1 throughout DRAIN -> ignored, array_en stays 1, matmul_done still in cycle 11.
- push_en while busy: pulse push_en in cycles 3 and 11 (DONE) -> ignored, single matmul_done; push_en in cycle 12 -> new PUSH starts in cycle 13.
- Back-to-back: two matmuls separated by one IDLE cycle -> skew shows zeros between them, and there are exactly two matmul_done pulses.

Source files
------------

// File: rtl/systolic_push_unit_pkg.sv
// Shared definitions for the matmul push path: array geometry defaults,
// warp indexing and the push FSM state encoding.
package systolic_push_unit_pkg;

  localparam int DIM       = 4;
  localparam int DATA_W    = 8;
  localparam int WARP_W    = 2;
  localparam int NUM_WARPS = 1 << WARP_W;

  // After the last row enters, the farthest lane needs this many more shifts
  // before every operand has crossed the array.
  localparam int DRAIN_LEN = 2 * DIM - 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PUSH  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } push_state_e;

  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/skew_delay_line.sv
// Enable-gated shift register of DEPTH stages; one per array row to build the
// diagonal skew on the west edge.
module skew_delay_line #(
  parameter int DEPTH  = 1,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);

  logic [DATA_W-1:0] stages [DEPTH];

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int s = 0; s < DEPTH; s++) begin
        stages[s] <= '0;
      end
    end else if (en) begin
      stages[0] <= din;
      for (int s = 1; s < DEPTH; s++) begin
        stages[s] <= stages[s-1];
      end
    end
  end

  assign dout = stages[DEPTH-1];

endmodule

// File: rtl/systolic_push_unit.sv
// Reads one operand row per accepted cycle from the register file and feeds
// it, diagonally skewed, into the west edge of the systolic array.
module systolic_push_unit #(
  parameter int DIM    = systolic_push_unit_pkg::DIM,
  parameter int DATA_W = systolic_push_unit_pkg::DATA_W,
  parameter int WARP_W = systolic_push_unit_pkg::WARP_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push_en,
  input  logic [WARP_W-1:0]     push_warp,
  input  logic                  pause,
  output logic                  rf_rd_en,
  output logic [WARP_W-1:0]     rf_rd_warp,
  input  logic [DIM*DATA_W-1:0] rf_rd_data,
  output logic [DIM*DATA_W-1:0] array_west_data,
  output logic                  array_en,
  output logic                  busy,
  output logic                  matmul_done
);

  import systolic_push_unit_pkg::*;

  localparam int DRAIN_CYCLES = 2 * DIM - 2;
  localparam int CNT_W        = cnt_width(DRAIN_CYCLES);
  localparam logic [CNT_W-1:0] ROW_LAST   = CNT_W'(DIM - 1);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_CYCLES - 1);

  push_state_e          state;
  push_state_e          state_nxt;
  logic [CNT_W-1:0]     row_cnt;
  logic [CNT_W-1:0]     row_cnt_nxt;
  logic [CNT_W-1:0]     drain_cnt;
  logic [CNT_W-1:0]     drain_cnt_nxt;
  logic                 accept;
  logic [DIM*DATA_W-1:0] stage0_in;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= ST_IDLE;
      row_cnt   <= '0;
      drain_cnt <= '0;
    end else begin
      state     <= state_nxt;
      row_cnt   <= row_cnt_nxt;
      drain_cnt <= drain_cnt_nxt;
    end
  end

  // Read handshake: a row is transferred in every PUSH cycle where pause is
  // low; rf_rd_en marks that cycle and rf_rd_data is consumed combinationally
  // in the same cycle. A paused cycle transfers nothing and freezes the array.
  always_comb begin
    state_nxt     = state;
    row_cnt_nxt   = row_cnt;
    drain_cnt_nxt = drain_cnt;
    rf_rd_en      = 1'b0;
    rf_rd_warp    = '0;
    array_en      = 1'b0;
    matmul_done   = 1'b0;
    accept        = 1'b0;
    case (state)
      ST_IDLE: begin
        if (push_en) begin
          state_nxt   = ST_PUSH;
          row_cnt_nxt = '0;
        end
      end
      ST_PUSH: begin
        rf_rd_warp = push_warp;
        if (!pause) begin
          rf_rd_en    = 1'b1;
          accept      = 1'b1;
          array_en    = 1'b1;
          row_cnt_nxt = row_cnt + 1'b1;
          if (row_cnt == ROW_LAST) begin
            state_nxt     = ST_DRAIN;
            drain_cnt_nxt = '0;
          end
        end
      end
      ST_DRAIN: begin
        array_en      = 1'b1;
        drain_cnt_nxt = drain_cnt + 1'b1;
        if (drain_cnt == DRAIN_LAST) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        matmul_done = 1'b1;
        state_nxt   = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  assign busy      = (state != ST_IDLE);
  assign stage0_in = accept ? rf_rd_data : '0;

  // Lane i sits behind i+1 registers so row elements reach the array edge on
  // a diagonal wavefront.
  for (genvar i = 0; i < DIM; i++) begin : g_lane
    skew_delay_line #(
      .DEPTH  (i + 1),
      .DATA_W (DATA_W)
    ) u_skew (
      .clk   (clk),
      .reset (reset),
      .en    (array_en),
      .din   (stage0_in[i*DATA_W +: DATA_W]),
      .dout  (array_west_data[i*DATA_W +: DATA_W])
    );
  end

endmodule

// File: tb/tb_systolic_push_unit.sv
// Directed bench for systolic_push_unit: cycle-exact control checks plus a
// per-lane expected-value queue drained as skewed operands appear.
module tb_systolic_push_unit;
  import systolic_push_unit_pkg::*;

  localparam int W = DIM * DATA_W;

  logic              clk = 1'b0;
  logic              reset;
  logic              push_en;
  logic              pause;
  logic [WARP_W-1:0] push_warp;
  logic [WARP_W-1:0] rf_rd_warp;
  logic [W-1:0]      rf_rd_data;
  logic [W-1:0]      array_west_data;
  logic              rf_rd_en;
  logic              array_en;
  logic              busy;
  logic              matmul_done;

  logic [W-1:0]      rf_mem [NUM_WARPS];
  logic [DATA_W-1:0] exp_q [DIM][$];

  int checks   = 0;
  int failures = 0;
  int done_cnt = 0;
  bit sb_on    = 1'b0;
  bit prev_en  = 1'b0;

  int cfg_p_at       = 0;
  int cfg_p_len      = 0;
  bit cfg_drain_pause = 1'b0;
  bit cfg_pokes      = 1'b0;
  bit cfg_rand_warp  = 1'b0;
  int cfg_lane_mode  = 0;

  always #5 clk = ~clk;

  assign rf_rd_data = rf_mem[rf_rd_warp];

  systolic_push_unit dut (
    .clk             (clk),
    .reset           (reset),
    .push_en         (push_en),
    .push_warp       (push_warp),
    .pause           (pause),
    .rf_rd_en        (rf_rd_en),
    .rf_rd_warp      (rf_rd_warp),
    .rf_rd_data      (rf_rd_data),
    .array_west_data (array_west_data),
    .array_en        (array_en),
    .busy            (busy),
    .matmul_done     (matmul_done)
  );

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: each new value shifted onto a lane must match the oldest
  // expected element queued for that lane.
  always @(negedge clk) begin
    if (reset && matmul_done) done_cnt++;
    if (reset && sb_on && prev_en) begin
      for (int i = 0; i < DIM; i++) begin
        logic [DATA_W-1:0] v;
        logic [DATA_W-1:0] e;
        v = array_west_data[i*DATA_W +: DATA_W];
        if (v != '0) begin
          checks++;
          assert (exp_q[i].size() != 0) else begin
            failures++;
            $error("FAIL sb_extra lane%0d: got %0h expected none", i, v);
          end
          if (exp_q[i].size() != 0) begin
            e = exp_q[i].pop_front();
            chk($sformatf("sb_lane%0d", i), W'(v), W'(e));
          end
        end
      end
    end
    prev_en = reset && array_en;
  end

  // Starts a matmul in the current cycle (cycle 0) and checks every cycle up
  // to the expected DONE cycle, then the following IDLE cycle.
  task automatic run_matmul(input int exp_done);
    int row;
    int w;
    row = 0;
    push_en = 1'b1;
    pause   = 1'b0;
    #3;
    chk("start_idle_busy", W'(busy), W'(0));
    for (int k = 1; k <= exp_done; k++) begin
      tick();
      push_en = cfg_pokes && (k == 3 || k == exp_done);
      if (row < DIM) begin
        pause = (k >= cfg_p_at) && (k < cfg_p_at + cfg_p_len);
        w = cfg_rand_warp ? int'($urandom_range(0, NUM_WARPS - 1)) : (row % NUM_WARPS);
        push_warp = WARP_W'(w);
        #3;
        chk("push_rd_en", W'(rf_rd_en), W'(!pause));
        chk("push_rd_warp", W'(rf_rd_warp), W'(w));
        chk("push_array_en", W'(array_en), W'(!pause));
        if (!pause) begin
          for (int i = 0; i < DIM; i++) exp_q[i].push_back(rf_mem[w][i*DATA_W +: DATA_W]);
          row++;
        end
      end else if (k < exp_done) begin
        pause = cfg_drain_pause;
        #3;
        chk("drain_array_en", W'(array_en), W'(1));
        chk("drain_rd_en", W'(rf_rd_en), W'(0));
      end else begin
        pause = 1'b0;
        #3;
        chk("done_array_en", W'(array_en), W'(0));
        chk("done_west_zero", array_west_data, W'(0));
      end
      chk("busy", W'(busy), W'(1));
      chk("done_pulse", W'(matmul_done), W'(k == exp_done));
      if (cfg_lane_mode == 1 && k >= 2 && k <= 5)
        chk("clean_lane0", W'(array_west_data[DATA_W-1:0]), W'(rf_mem[k-2][DATA_W-1:0]));
      if (cfg_lane_mode == 1 && k >= 5 && k <= 8)
        chk("clean_lane3", W'(array_west_data[3*DATA_W +: DATA_W]), W'(rf_mem[k-5][3*DATA_W +: DATA_W]));
      if (cfg_lane_mode == 2 && k >= 3 && k <= 6)
        chk("pause_frozen_lane0", W'(array_west_data[DATA_W-1:0]), W'(8'h05));
    end
    tick();
    push_en = 1'b0;
    pause   = 1'b0;
    #3;
    chk("after_busy", W'(busy), W'(0));
    chk("after_done", W'(matmul_done), W'(0));
    chk("after_west_zero", array_west_data, W'(0));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rd_en"}, W'(rf_rd_en), W'(0));
    chk({tag, "_rd_warp"}, W'(rf_rd_warp), W'(0));
    chk({tag, "_array_en"}, W'(array_en), W'(0));
    chk({tag, "_busy"}, W'(busy), W'(0));
    chk({tag, "_done"}, W'(matmul_done), W'(0));
    chk({tag, "_west"}, array_west_data, W'(0));
  endtask

  initial begin
    int done_base;
    reset     = 1'b0;
    push_en   = 1'b0;
    pause     = 1'b0;
    push_warp = WARP_W'(2);
    rf_mem[0] = 32'h04030201;
    rf_mem[1] = 32'h08070605;
    rf_mem[2] = 32'h0C0B0A09;
    rf_mem[3] = 32'h100F0E0D;

    // clock/reset
    tick();
    tick();
    #3;
    chk_all_zero("init_rst");
    tick();
    reset = 1'b1;
    #3;
    chk_all_zero("init_idle");
    sb_on = 1'b1;

    // clean matmul
    cfg_lane_mode = 1;
    run_matmul(3 * DIM - 1);

    // three pause cycles after the second row
    cfg_lane_mode = 2;
    cfg_p_at  = 3;
    cfg_p_len = 3;
    run_matmul(3 * DIM - 1 + 3);
    cfg_lane_mode = 0;
    cfg_p_len = 0;

    // pause held high throughout DRAIN
    cfg_drain_pause = 1'b1;
    run_matmul(3 * DIM - 1);
    cfg_drain_pause = 1'b0;

    // push_en pulsed in cycle 3 and in DONE, then a real start in cycle 12
    cfg_pokes = 1'b1;
    run_matmul(3 * DIM - 1);
    cfg_pokes = 1'b0;
    run_matmul(3 * DIM - 1);

    // back-to-back with random rows and warps
    for (int n = 0; n < NUM_WARPS; n++)
      for (int i = 0; i < DIM; i++)
        rf_mem[n][i*DATA_W +: DATA_W] = DATA_W'($urandom_range(1, (1 << DATA_W) - 1));
    cfg_rand_warp = 1'b1;
    done_base = done_cnt;
    tick();
    run_matmul(3 * DIM - 1);
    run_matmul(3 * DIM - 1);
    chk("b2b_done_count", W'(done_cnt - done_base), W'(2));
    cfg_rand_warp = 1'b0;

    for (int i = 0; i < DIM; i++) chk("sb_drained", W'(exp_q[i].size()), W'(0));

    // reset in the middle of PUSH
    sb_on = 1'b0;
    done_base = done_cnt;
    tick();
    push_en = 1'b1;
    tick();
    push_en = 1'b0;
    push_warp = WARP_W'(0);
    tick();
    push_warp = WARP_W'(1);
    #3;
    chk("mid_pre_busy", W'(busy), W'(1));
    tick();
    reset = 1'b0;
    push_warp = WARP_W'(3);
    tick();
    #3;
    chk_all_zero("mid_rst0");
    tick();
    #3;
    chk_all_zero("mid_rst1");
    tick();
    reset = 1'b1;
    #3;
    chk_all_zero("mid_rel0");
    for (int c = 1; c <= 4; c++) begin
      tick();
      #3;
      chk("mid_rel_west", array_west_data, W'(0));
      chk("mid_rel_busy", W'(busy), W'(0));
      chk("mid_rel_done", W'(matmul_done), W'(0));
    end
    chk("mid_no_done", W'(done_cnt - done_base), W'(0));
    chk("done_total", W'(done_cnt), W'(7));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
